// File: rtl/spi_reg_bridge.sv
// Command parser between the SPI slave word interface and a register-bank port.
// Optional write-burst idle timeout is built only when SPI_BRIDGE_TIMEOUT_EN is defined.
module spi_reg_bridge #(
    parameter int NREGS   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_available,
    output logic              rx_ack,
    input  logic [0:15]       rx_data,
    input  logic              tx_free,
    output logic              tx_en,
    output logic [0:15]       tx_data,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [0:15]       reg_wdata,
    input  logic [0:15]       reg_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, WDATA, RREQ, RCAP, RSEND} state_t;

    // A misconfigured instance rejects every header instead of addressing the wrong registers.
    localparam bit CFG_OK = (NREGS == (1 << ADDR_W)) && (NREGS <= 256) && (TIMEOUT >= 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        cnt;

    logic              hdr_write;
    logic [6:0]        hdr_len;
    logic [7:0]        hdr_addr;
    logic              hdr_bad;
    logic              take;
    logic              step;
    logic              err_next;

    assign hdr_write = rx_data[0];
    assign hdr_len   = rx_data[1:7];
    assign hdr_addr  = rx_data[8:15];
    assign hdr_bad   = !CFG_OK || (hdr_len == 7'd0) || ((hdr_addr >> ADDR_W) != 8'd0);

    assign reg_addr  = addr;
    assign busy      = (state != IDLE);

`ifdef SPI_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero outside WDATA so every burst starts with a fresh idle budget.
    always_ff @(posedge clk) begin
        if (reset || (state != WDATA) || take) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    always_comb begin
        state_next = state;
        take       = 1'b0;
        step       = 1'b0;
        err_next   = 1'b0;
        tx_en      = 1'b0;
        reg_rd_en  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_available && !rx_ack) begin
                    take = 1'b1;
                    if (hdr_bad) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = hdr_write ? WDATA : RREQ;
                    end
                end
            end
            WDATA: begin
                // The write strobe cycle doubles as the ack cycle, so no word can be taken in it.
                if (reg_wr_en) begin
                    step = 1'b1;
                    if (cnt == 7'd1) begin
                        state_next = IDLE;
                    end
                end else if (rx_available && !rx_ack) begin
                    take = 1'b1;
                end
`ifdef SPI_BRIDGE_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            RREQ: begin
                reg_rd_en  = 1'b1;
                state_next = RCAP;
            end
            RCAP: begin
                state_next = RSEND;
            end
            RSEND: begin
                if (tx_free) begin
                    tx_en      = 1'b1;
                    step       = 1'b1;
                    state_next = (cnt == 7'd1) ? IDLE : RREQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            rx_ack    <= 1'b0;
            err       <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_wdata <= '0;
            tx_data   <= '0;
        end else begin
            state     <= state_next;
            rx_ack    <= take;
            err       <= err_next;
            reg_wr_en <= take && (state == WDATA);
            if (take && (state == WDATA)) begin
                reg_wdata <= rx_data;
            end
            if (state == RCAP) begin
                tx_data <= reg_rdata;
            end
            // Address wraps naturally because NREGS is exactly 2**ADDR_W.
            if (take && (state == IDLE) && !hdr_bad) begin
                addr <= hdr_addr[ADDR_W-1:0];
                cnt  <= hdr_len;
            end else if (step) begin
                addr <= addr + ADDR_W'(1);
                cnt  <= cnt - 7'd1;
            end else if (err_next) begin
                cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected strobes are queued by the stimulus
// and popped by an independent monitor whenever the DUT raises a strobe.
module tb_spi_reg_bridge;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_available;
    logic              rx_ack;
    logic [0:15]       rx_data;
    logic              tx_free;
    logic              tx_en;
    logic [0:15]       tx_data;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [0:15]       reg_wdata;
    logic [0:15]       reg_rdata;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    spi_reg_bridge #(.NREGS(16), .ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
        .clk(clk),
        .reset(reset),
        .rx_available(rx_available),
        .rx_ack(rx_ack),
        .rx_data(rx_data),
        .tx_free(tx_free),
        .tx_en(tx_en),
        .tx_data(tx_data),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .busy(busy),
        .err(err)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } event_t;

    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_TX  = 2'd2;
    localparam logic [1:0] EV_ERR = 2'd3;

    event_t      expQ[$];
    int          errors   = 0;
    int          checks   = 0;
    int          ackCount = 0;
    int          expAcks  = 0;
    logic [15:0] mem [0:15];
    logic        stallOk;

    // Register-file model: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (reg_rd_en) begin
            reg_rdata <= mem[reg_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input logic [1:0] kind, input logic [7:0] addr, input logic [15:0] data);
        event_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic checkEvent(input logic [1:0] kind, input logic [7:0] addr, input logic [15:0] data);
        event_t e;
        event_t got;
        got.kind = kind;
        got.addr = addr;
        got.data = data;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind=%0d addr=%0h data=%0h, expected none", kind, addr, data);
        end else begin
            e = expQ.pop_front();
            if (e !== got) begin
                errors++;
                $display("[TB] FAIL event: got kind=%0d addr=%0h data=%0h, expected kind=%0d addr=%0h data=%0h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_ack) ackCount++;
            if (reg_wr_en && reg_rd_en) begin
                checks++;
                errors++;
                $display("[TB] FAIL strobe_overlap: got wr=1 rd=1, expected at most one");
            end
            if (reg_wr_en) checkEvent(EV_WR, 8'(reg_addr), reg_wdata);
            if (reg_rd_en) checkEvent(EV_RD, 8'(reg_addr), 16'h0000);
            if (tx_en)     checkEvent(EV_TX, 8'h00, tx_data);
            if (err)       checkEvent(EV_ERR, 8'h00, 16'h0000);
        end
    end

    task automatic applyStimulus(input logic [15:0] word);
        int n;
        n = 0;
        @(posedge clk); #1;
        rx_data      = word;
        rx_available = 1'b1;
        expAcks++;
        while (n < 50) begin
            @(negedge clk);
            if (rx_ack) break;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_ack_timeout: got no ack for %0h, expected ack within 50 cycles", word);
        end
        rx_available = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, busy, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},      busy,      0);
        checkOutput({tag, "_rx_ack"},    rx_ack,    0);
        checkOutput({tag, "_tx_en"},     tx_en,     0);
        checkOutput({tag, "_wr_en"},     reg_wr_en, 0);
        checkOutput({tag, "_rd_en"},     reg_rd_en, 0);
        checkOutput({tag, "_err"},       err,       0);
        checkOutput({tag, "_reg_addr"},  reg_addr,  0);
        checkOutput({tag, "_tx_data"},   tx_data,   0);
        checkOutput({tag, "_reg_wdata"}, reg_wdata, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        rx_available = 1'b0;
        rx_data      = '0;
        tx_free      = 1'b1;
        reg_rdata    = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[15] = 16'hAAAA;
        mem[0]  = 16'h5555;
        mem[5]  = 16'hBEEF;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Write burst W=1 LEN=3 addr=2.
        expectEvent(EV_WR, 8'd2, 16'h1111);
        expectEvent(EV_WR, 8'd3, 16'h2222);
        expectEvent(EV_WR, 8'd4, 16'h3333);
        applyStimulus(16'h8302);
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        applyStimulus(16'h3333);
        checkOutput("busy_during_last_write", busy, 1);
        @(negedge clk);
        checkOutput("busy_after_write_burst", busy, 0);

        // Read burst W=0 LEN=2 addr=15, wrapping to 0.
        expectEvent(EV_RD, 8'd15, 16'h0000);
        expectEvent(EV_TX, 8'd0,  16'hAAAA);
        expectEvent(EV_RD, 8'd0,  16'h0000);
        expectEvent(EV_TX, 8'd0,  16'h5555);
        applyStimulus(16'h020F);
        waitIdle("busy_after_read_wrap");

        // Single read held off by tx_free.
        @(posedge clk); #1;
        tx_free = 1'b0;
        expectEvent(EV_RD, 8'd5, 16'h0000);
        expectEvent(EV_TX, 8'd0, 16'hBEEF);
        applyStimulus(16'h0105);
        repeat (2) @(negedge clk);
        stallOk = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_en || (tx_data !== 16'hBEEF)) stallOk = 1'b0;
        end
        checkOutput("stall_hold", stallOk, 1);
        checkOutput("stall_busy", busy, 1);
        @(posedge clk); #1;
        tx_free = 1'b1;
        @(negedge clk);
        checkOutput("tx_en_on_free", tx_en, 1);
        @(negedge clk);
        checkOutput("busy_after_stall", busy, 0);

        // Rejected headers: LEN=0, then address beyond the bank.
        expectEvent(EV_ERR, 8'd0, 16'h0000);
        applyStimulus(16'h8005);
        checkOutput("busy_after_len0", busy, 0);
        expectEvent(EV_ERR, 8'd0, 16'h0000);
        applyStimulus(16'h8110);
        checkOutput("busy_after_bad_addr", busy, 0);

        // Reset after one of three write words, then a normal burst.
        expectEvent(EV_WR, 8'd2, 16'h7777);
        applyStimulus(16'h8302);
        applyStimulus(16'h7777);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkAllZero("midreset");
        reset = 1'b0;
        expectEvent(EV_WR, 8'd9, 16'h4242);
        applyStimulus(16'h8109);
        applyStimulus(16'h4242);
        @(negedge clk);
        checkOutput("busy_after_post_reset", busy, 0);

        // Write burst left short: LEN=2 addr=6 with only one data word.
        expectEvent(EV_WR, 8'd6, 16'h1234);
`ifdef SPI_BRIDGE_TIMEOUT_EN
        expectEvent(EV_ERR, 8'd0, 16'h0000);
`endif
        applyStimulus(16'h8206);
        applyStimulus(16'h1234);
        repeat (40) @(negedge clk);
`ifdef SPI_BRIDGE_TIMEOUT_EN
        checkOutput("busy_after_timeout", busy, 0);
`else
        checkOutput("busy_waiting_no_timeout", busy, 1);
        expectEvent(EV_WR, 8'd7, 16'h5678);
        applyStimulus(16'h5678);
        @(negedge clk);
        checkOutput("busy_after_late_word", busy, 0);
`endif

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("ack_count", ackCount, expAcks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
